user_rq_credit_arbiter: RTL and testbench

// Round-robin arbiter that merges N_SRCS user read-request streams into the single request stream feeding
// the user-side read demux (resp/recv steering). Each source owns a beat-credit pool that mirrors its

---
 rtl/user_rq_credit_arbiter.sv | 124 ++++++++++++
 tb/tb_user_rq_credit_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/user_rq_credit_arbiter.sv
// Round-robin merge of N_SRCS read-request streams into one registered output slot.
// A source is granted only when its per-source beat-credit pool covers the whole burst.
module user_rq_credit_arbiter #(
  parameter  int N_SRCS     = 4,
  parameter  int REQ_BITS   = 128,
  parameter  int LEN_BITS   = 28,
  parameter  int BEAT_LOG   = 6,
  parameter  int CRED_BEATS = 64,
  localparam int SRC_W      = (N_SRCS > 1) ? $clog2(N_SRCS) : 1,
  localparam int CRED_W     = (CRED_BEATS > 0) ? $clog2(CRED_BEATS + 1) : 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_SRCS-1:0]            s_rq_valid,
  output logic [N_SRCS-1:0]            s_rq_ready,
  input  logic [N_SRCS*REQ_BITS-1:0]   s_rq_data,
  input  logic [N_SRCS*LEN_BITS-1:0]   s_rq_len,
  output logic                         m_rq_valid,
  input  logic                         m_rq_ready,
  output logic [REQ_BITS-1:0]          m_rq_data,
  output logic [SRC_W-1:0]             m_rq_src,
  input  logic [N_SRCS-1:0]            cred_ret,
  output logic                         cred_err
);

  localparam int CMP_W = (LEN_BITS > CRED_W) ? LEN_BITS : CRED_W;

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t              state_q, state_d;
  logic [REQ_BITS-1:0] m_data_q, m_data_d;
  logic [SRC_W-1:0]    m_src_q, m_src_d;
  logic [SRC_W-1:0]    rr_q, rr_d;
  logic [CRED_W-1:0]   cred_q [N_SRCS];
  logic [CRED_W-1:0]   cred_d [N_SRCS];
  logic                cred_err_q, cred_err_d;

  logic [LEN_BITS-1:0] beats [N_SRCS];
  logic [N_SRCS-1:0]   len_zero;
  logic [N_SRCS-1:0]   elig;
  logic                slot_free;
  logic                gnt_vld;
  logic                gnt;
  logic [SRC_W-1:0]    gnt_idx;

  // A zero-length request still occupies one beat in the destination buffer.
  always_comb begin
    for (int i = 0; i < N_SRCS; i++) begin
      len_zero[i] = (s_rq_len[i*LEN_BITS +: LEN_BITS] == '0);
      beats[i]    = len_zero[i] ? LEN_BITS'(1)
                  : ((s_rq_len[i*LEN_BITS +: LEN_BITS] - LEN_BITS'(1)) >> BEAT_LOG) + LEN_BITS'(1);
      elig[i]     = s_rq_valid[i] && (CMP_W'(cred_q[i]) >= CMP_W'(beats[i]));
    end
  end

  // Scan from the far end back to rr so the closest eligible index wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_SRCS - 1; k >= 0; k--) begin
      if (elig[(int'(rr_q) + k) % N_SRCS]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'((int'(rr_q) + k) % N_SRCS);
      end
    end
  end

  assign slot_free  = (state_q == ST_IDLE) || m_rq_ready;
  assign gnt        = gnt_vld && slot_free && aresetn;
  assign s_rq_ready = gnt ? (N_SRCS'(1) << gnt_idx) : '0;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    m_data_d   = m_data_q;
    m_src_d    = m_src_q;
    rr_d       = rr_q;
    cred_err_d = cred_err_q;
    if (gnt) begin
      state_d  = ST_HOLD;
      m_data_d = s_rq_data[gnt_idx*REQ_BITS +: REQ_BITS];
      m_src_d  = gnt_idx;
      rr_d     = (gnt_idx == SRC_W'(N_SRCS - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end else if (slot_free) begin
      state_d = ST_IDLE;
    end
    for (int i = 0; i < N_SRCS; i++) begin
      cred_d[i] = cred_q[i];
      if (gnt && (gnt_idx == SRC_W'(i))) begin
        cred_d[i] = cred_q[i] - CRED_W'(beats[i]) + CRED_W'(cred_ret[i]);
      end else if (cred_ret[i]) begin
        if (cred_q[i] == CRED_W'(CRED_BEATS)) cred_err_d = 1'b1;
        else                                  cred_d[i] = cred_q[i] + CRED_W'(1);
      end
      if (s_rq_valid[i] && len_zero[i]) cred_err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      m_data_q   <= '0;
      m_src_q    <= '0;
      rr_q       <= '0;
      cred_err_q <= 1'b0;
      // NOTE: the credit array is control state, not data storage, so every entry is reset.
      for (int i = 0; i < N_SRCS; i++) cred_q[i] <= CRED_W'(CRED_BEATS);
    end else begin
      state_q    <= state_d;
      m_data_q   <= m_data_d;
      m_src_q    <= m_src_d;
      rr_q       <= rr_d;
      cred_err_q <= cred_err_d;
      for (int i = 0; i < N_SRCS; i++) cred_q[i] <= cred_d[i];
    end
  end

  assign m_rq_valid = (state_q == ST_HOLD);
  assign m_rq_data  = m_data_q;
  assign m_rq_src   = m_src_q;
  assign cred_err   = cred_err_q;

endmodule

// File: tb/tb_user_rq_credit_arbiter.sv
// Directed bench for user_rq_credit_arbiter: grant order, credit gating, back-pressure,
// credit return/saturation and asynchronous reset, with hand-computed expectations.
module tb_user_rq_credit_arbiter;

  localparam int N  = 4;
  localparam int RB = 128;
  localparam int LB = 28;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [N-1:0]    s_rq_valid = '0;
  logic [N-1:0]    s_rq_ready;
  logic [N*RB-1:0] s_rq_data = '0;
  logic [N*LB-1:0] s_rq_len = '0;
  logic            m_rq_valid;
  logic            m_rq_ready = 1'b0;
  logic [RB-1:0]   m_rq_data;
  logic [1:0]      m_rq_src;
  logic [N-1:0]    cred_ret = '0;
  logic            cred_err;

  int n_vec = 0;
  int n_err = 0;

  user_rq_credit_arbiter dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_rq_valid (s_rq_valid),
    .s_rq_ready (s_rq_ready),
    .s_rq_data  (s_rq_data),
    .s_rq_len   (s_rq_len),
    .m_rq_valid (m_rq_valid),
    .m_rq_ready (m_rq_ready),
    .m_rq_data  (m_rq_data),
    .m_rq_src   (m_rq_src),
    .cred_ret   (cred_ret),
    .cred_err   (cred_err)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [RB-1:0] obs, input logic [RB-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RB-1:0] data_of(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_len(input int i, input int len);
    s_rq_len[i*LB +: LB] = LB'(len);
  endtask

  task automatic do_reset();
    s_rq_valid = '0;
    cred_ret   = '0;
    m_rq_ready = 1'b0;
    aresetn    = 1'b0;
    tick();
    aresetn = 1'b1;
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) s_rq_data[i*RB +: RB] = data_of(i);

    // 1: reset state, then a single 4-beat request
    do_reset();
    check("rst_valid", m_rq_valid, 0);
    check("rst_data", m_rq_data, 0);
    check("rst_src", m_rq_src, 0);
    check("rst_err", cred_err, 0);
    check("rst_cred0", dut.cred_q[0], 64);
    set_len(0, 256);
    s_rq_valid = 4'b0001;
    #1;
    check("t1_ready", s_rq_ready, 4'b0001);
    tick();
    s_rq_valid = '0;
    check("t1_valid", m_rq_valid, 1);
    check("t1_src", m_rq_src, 0);
    check("t1_data", m_rq_data, data_of(0));
    check("t1_cred0", dut.cred_q[0], 60);
    m_rq_ready = 1'b1;
    tick();
    check("t1_idle", m_rq_valid, 0);

    // 2: all sources valid, full credits -> strict rotation one per cycle
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 64);
    s_rq_valid = 4'b1111;
    m_rq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t2_ready", s_rq_ready, 4'b0001 << (k % 4));
      tick();
      check("t2_src", m_rq_src, k % 4);
      check("t2_data", m_rq_data, data_of(k % 4));
    end

    // 3: insufficient credit skips src1 until one credit returns
    do_reset();
    m_rq_ready = 1'b1;
    set_len(1, 3904);          // 61 beats -> leaves 3
    s_rq_valid = 4'b0010;
    #1;
    check("t3_pre_ready", s_rq_ready, 4'b0010);
    tick();
    check("t3_cred1_3", dut.cred_q[1], 3);
    set_len(1, 256);
    set_len(2, 64);
    s_rq_valid = 4'b0110;
    #1;
    check("t3_skip_ready", s_rq_ready, 4'b0100);
    tick();
    check("t3_src2", m_rq_src, 2);
    s_rq_valid = 4'b0010;
    cred_ret   = 4'b0010;
    #1;
    check("t3_starve_ready", s_rq_ready, 4'b0000);
    tick();
    cred_ret = '0;
    #1;
    check("t3_cred1_4", dut.cred_q[1], 4);
    check("t3_retry_ready", s_rq_ready, 4'b0010);
    tick();
    s_rq_valid = '0;
    check("t3_src1", m_rq_src, 1);
    check("t3_data1", m_rq_data, data_of(1));
    check("t3_cred1_0", dut.cred_q[1], 0);

    // 4: back-pressure holds the slot stable with no grants
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 64);
    s_rq_valid = 4'b1111;
    m_rq_ready = 1'b1;
    #1;
    check("t4_first_ready", s_rq_ready, 4'b0001);
    tick();
    m_rq_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_hold_ready", s_rq_ready, 4'b0000);
      tick();
      check("t4_hold_valid", m_rq_valid, 1);
      check("t4_hold_src", m_rq_src, 0);
      check("t4_hold_data", m_rq_data, data_of(0));
    end
    m_rq_ready = 1'b1;
    #1;
    check("t4_resume_ready", s_rq_ready, 4'b0010);
    tick();
    check("t4_resume_src", m_rq_src, 1);
    s_rq_valid = '0;

    // 5: same-cycle return and grant, then saturation error
    do_reset();
    m_rq_ready = 1'b1;
    set_len(0, 3456);          // 54 beats -> leaves 10
    s_rq_valid = 4'b0001;
    tick();
    check("t5_cred0_10", dut.cred_q[0], 10);
    set_len(0, 64);
    cred_ret = 4'b0001;
    #1;
    check("t5_ready", s_rq_ready, 4'b0001);
    tick();
    s_rq_valid = '0;
    check("t5_cred0_same", dut.cred_q[0], 10);
    for (int k = 0; k < 54; k++) tick();
    check("t5_cred0_full", dut.cred_q[0], 64);
    check("t5_err_clear", cred_err, 0);
    tick();
    cred_ret = '0;
    check("t5_err_set", cred_err, 1);
    check("t5_cred0_sat", dut.cred_q[0], 64);
    tick();
    check("t5_err_sticky", cred_err, 1);

    // 6: async reset while holding a beat
    do_reset();
    set_len(0, 256);
    set_len(1, 64);
    s_rq_valid = 4'b0001;
    tick();
    s_rq_valid = 4'b0011;
    check("t6_hold", m_rq_valid, 1);
    aresetn = 1'b0;
    #1;
    check("t6_async_valid", m_rq_valid, 0);
    check("t6_async_src", m_rq_src, 0);
    check("t6_async_data", m_rq_data, 0);
    check("t6_async_ready", s_rq_ready, 4'b0000);
    check("t6_cred0", dut.cred_q[0], 64);
    check("t6_cred3", dut.cred_q[3], 64);
    aresetn = 1'b1;
    #1;
    check("t6_rr0_ready", s_rq_ready, 4'b0001);
    s_rq_valid = '0;

    // 7: oversize burst starves, zero-length counts one beat and flags error
    do_reset();
    m_rq_ready = 1'b1;
    set_len(0, 4160);          // 65 beats, never fits
    set_len(1, 64);
    set_len(3, 0);
    s_rq_valid = 4'b1011;
    #1;
    check("t7_skip_big", s_rq_ready, 4'b0010);
    tick();
    check("t7_src1", m_rq_src, 1);
    check("t7_len0_err", cred_err, 1);
    s_rq_valid = 4'b1001;
    #1;
    check("t7_len0_ready", s_rq_ready, 4'b1000);
    tick();
    check("t7_src3", m_rq_src, 3);
    check("t7_cred3", dut.cred_q[3], 63);
    s_rq_valid = 4'b0001;
    #1;
    check("t7_starve", s_rq_ready, 4'b0000);
    s_rq_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
